// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path: default sizes,
// complex sample type and a width-parameterised bit-reversal.
package fft_pkg;

  localparam int FFT_N_LOG2  = 4;
  localparam int FFT_W       = 17;
  localparam int BITREV_MAXW = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Reverses the low nbits of v; bits above nbits come back as zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(
    input logic [BITREV_MAXW-1:0] v,
    input int                     nbits
  );
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int k = 0; k < BITREV_MAXW; k++) begin
      if (k < nbits) r[k] = v[nbits-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_dpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read latency 1 cycle; no backpressure, contents are never reset.
module reorder_dpram #(
  parameter int AW = 5,
  parameter int DW = 34
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdat;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    if (i_re) r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of bit-reversed FFT output into natural order; latency 2 cycles
// after the last input of a frame, no backpressure. Optional sop/eop via FFT_REORDER_SOP_EN.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int W      = FFT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                valid_out,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im
`ifdef FFT_REORDER_SOP_EN
  ,
  output logic                sop_out,
  output logic                eop_out
`endif
);

  localparam int                AW   = N_LOG2 + 1;
  localparam logic [N_LOG2-1:0] LAST = '1;

  logic [N_LOG2-1:0] r_wr_idx;
  logic              r_wr_bank;
  logic [N_LOG2-1:0] r_rd_idx;
  logic              r_rd_bank;
  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic              w_handoff;
  logic              w_rd_en;
  logic              w_rd_last;
  logic [N_LOG2-1:0] w_wr_addr_lo;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [2*W-1:0]    w_rd_dat;
  logic              r_ram_vld;

  assign w_handoff    = valid_in && (r_wr_idx == LAST);
  assign w_wr_addr_lo = N_LOG2'(bitrev(BITREV_MAXW'(r_wr_idx), N_LOG2));
  assign w_wr_addr    = {r_wr_bank, w_wr_addr_lo};
  assign w_rd_last    = (r_state == RD_READ) && (r_rd_idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_idx  <= '0;
      r_wr_bank <= 1'b0;
    end else if (valid_in) begin
      r_wr_idx <= r_wr_idx + 1'b1;
      if (r_wr_idx == LAST) r_wr_bank <= ~r_wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RD_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A handoff landing on the last read keeps the reader streaming into the new bank.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (w_handoff) w_state_nxt = RD_READ;
      RD_READ: if (w_rd_last && !w_handoff) w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en   = (r_state == RD_READ);
    w_rd_addr = {r_rd_bank, r_rd_idx};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_idx  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_handoff) begin
      r_rd_idx  <= '0;
      r_rd_bank <= r_wr_bank;
    end else if (w_rd_en) begin
      r_rd_idx <= r_rd_idx + 1'b1;
    end
  end

  reorder_dpram #(
    .AW(AW),
    .DW(2*W)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (valid_in),
    .i_waddr(w_wr_addr),
    .i_wdat ({in_re, in_im}),
    .i_re   (w_rd_en),
    .i_raddr(w_rd_addr),
    .o_rdat (w_rd_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ram_vld <= 1'b0;
    else      r_ram_vld <= w_rd_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      valid_out <= r_ram_vld;
      if (r_ram_vld) {out_re, out_im} <= w_rd_dat;
    end
  end

`ifdef FFT_REORDER_SOP_EN
  logic r_ram_sop;
  logic r_ram_eop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ram_sop <= 1'b0;
      r_ram_eop <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end else begin
      r_ram_sop <= w_rd_en && (r_rd_idx == '0);
      r_ram_eop <= w_rd_last;
      sop_out   <= r_ram_sop;
      eop_out   <= r_ram_eop;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised scoreboard bench for fft_bitrev_reorder (N_LOG2=4, W=17).
module tb_fft_bitrev_reorder;

  localparam int NL = 4;
  localparam int N  = 16;
  localparam int W  = 17;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                valid_in = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                valid_out;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
`ifdef FFT_REORDER_SOP_EN
  logic                sop_out;
  logic                eop_out;
`endif

  fft_bitrev_reorder #(
    .N_LOG2(NL),
    .W     (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .in_re    (in_re),
    .in_im    (in_im),
    .valid_out(valid_out),
    .out_re   (out_re),
    .out_im   (out_im)
`ifdef FFT_REORDER_SOP_EN
    ,
    .sop_out  (sop_out),
    .eop_out  (eop_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    int                  cyc;
    int                  j;
  } exp_t;

  exp_t                q[$];
  logic signed [W-1:0] fr_re[N];
  logic signed [W-1:0] fr_im[N];
  int                  fill     = 0;
  int                  cyc      = 0;
  int                  checks   = 0;
  int                  failures = 0;
  logic signed [W-1:0] last_re  = '0;
  logic signed [W-1:0] last_im  = '0;
  int                  pat[N]   = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int rev(input int x);
    int r;
    r = 0;
    for (int b = 0; b < NL; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: collect a frame in arrival order, then emit it sorted by frequency.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      fill = 0;
      q.delete();
    end else if (valid_in) begin
      fr_re[fill] = in_re;
      fr_im[fill] = in_im;
      fill++;
      if (fill == N) begin
        for (int k = 0; k < N; k++)
          for (int i = 0; i < N; i++)
            if (rev(i) == k) q.push_back('{fr_re[i], fr_im[i], cyc + 2 + k, k});
        fill = 0;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("reset_valid_out", 64'(valid_out), 0);
      chk("reset_out_re", out_re, 0);
      chk("reset_out_im", out_im, 0);
      last_re = '0;
      last_im = '0;
    end else if (valid_out) begin
      if (q.size() == 0) begin
        chk("spurious_valid_out", 64'(valid_out), 0);
      end else begin
        e = q.pop_front();
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_timing", cyc, e.cyc);
`ifdef FFT_REORDER_SOP_EN
        chk("sop_out", 64'(sop_out), 64'(e.j == 0));
        chk("eop_out", 64'(eop_out), 64'(e.j == N - 1));
`endif
      end
      last_re = out_re;
      last_im = out_im;
    end else begin
      chk("hold_out_re", out_re, last_re);
      chk("hold_out_im", out_im, last_im);
`ifdef FFT_REORDER_SOP_EN
      chk("idle_sop_eop", 64'({sop_out, eop_out}), 0);
`endif
    end
  end

  task automatic drive(input logic v, input int re, input int im);
    @(posedge clk);
    #1;
    valid_in = v;
    in_re    = W'(re);
    in_im    = W'(im);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  function automatic int rnd17();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  // mode 0: contiguous, 1: valid toggling 1,0, 2: random gaps with random data
  task automatic send_frame(input int base, input int mode);
    int v;
    for (int i = 0; i < N; i++) begin
      if (mode == 2) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, rnd17(), rnd17());
        drive(1'b1, rnd17(), rnd17());
      end else begin
        v = base + pat[i];
        drive(1'b1, v, -v);
        if (mode == 1) drive(1'b0, 0, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    send_frame(0, 0);
    idle(25);

    send_frame(0, 1);
    idle(25);

    for (int k = 0; k < 3; k++) send_frame(100 * k, 0);
    idle(25);

    for (int i = 0; i < 7; i++) drive(1'b1, 500 + i, 600 + i);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    send_frame(200, 0);
    idle(25);

    for (int i = 0; i < N; i++)
      drive(1'b1, (i % 2 == 0) ? -65536 : 65535, (i % 2 == 0) ? 65535 : -65536);
    idle(25);

    send_frame(0, 2);
    idle(5);
    send_frame(0, 2);
    send_frame(0, 2);
    for (int i = 0; i < 2 * N; i++) drive(1'b1, rnd17(), rnd17());
    idle(25);

    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
